conv_accum: RTL
===============

Name: conv_accum

Overview:
Downstream consumer of the N-bit signed multiplier stage. Accumulates KERNEL_NUM signed 2N-bit products, one convolution window at a time, and adds a per-window bias. Rounds, optionally applies ReLU, and saturates each window sum back to DATA_WIDTH. Feeds the next CNN layer or the pooling stage through a valid/ready output.

Parameters:
DATA_WIDTH, 8, operand width of the upstream multiplier; product width is 2*DATA_WIDTH; output width is DATA_WIDTH
KERNEL_NUM, 9, products per window (3x3 kernel); must be >= 2
ACC_WIDTH, 24, accumulator width; must be >= 2*DATA_WIDTH + clog2(KERNEL_NUM) + 1; no overflow detection inside the accumulator
OUT_SHIFT, 7, arithmetic right shift from accumulator scale to output scale; 0 to 2*DATA_WIDTH-2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous flush of the window and the output register
in_valid  in  1  in_prod is valid
in_ready  out  1  block accepts in_prod this cycle
in_prod  in  2*DATA_WIDTH  signed product from the multiplier
bias  in  DATA_WIDTH  signed bias at output scale; sampled with the first term of each window
relu_en  in  1  clamp negative results to 0; sampled with the last term of each window
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts out_data
out_data  out  DATA_WIDTH  signed result
out_sat  out  1  saturation was applied to out_data

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, acc=0, out_valid=0, out_data=0, out_sat=0. A window in progress is discarded.
- Term acceptance: a term is accepted when in_valid && in_ready.
- cnt tracks the term index, 0..KERNEL_NUM-1. It wraps to 0 after the last term is accepted.
- First term (cnt==0): acc <= sext(in_prod) + (sext(bias) << OUT_SHIFT).
- Middle terms (0<cnt<KERNEL_NUM-1): acc <= acc + sext(in_prod).
- Last term (cnt==KERNEL_NUM-1): compute sum = acc + sext(in_prod), then process it in order:
  - Rounding: r = (sum + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, i.e. round half up.
  - ReLU: if relu_en && r<0, r=0.
  - Saturation: clamp r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat=1 if the clamp changed the value. A ReLU-only change does not set out_sat.
  - Register out_data and out_sat, set out_valid=1.
- Latency: the result is valid the cycle after the last term is accepted.
- Throughput: one term per cycle when not stalled.
- Output hold: out_valid falls on out_valid && out_ready, unless a new result loads in the same cycle. out_data and out_sat stay stable while out_valid && !out_ready.
- in_ready = !(out_valid && !out_ready && cnt==KERNEL_NUM-1).
  - Non-last terms of the next window are accepted while a result is held.
  - Only the last term stalls.
- Simultaneous events:
  - Last term accepted in the same cycle as an output handshake: the new result loads and out_valid stays 1.
  - in_valid while in_ready=0: nothing changes.
- clear=1: cnt=0, acc=0, out_valid=0, out_sat=0. clear has priority over a term accepted in the same cycle, and that term is dropped.
- in_ready is combinational from out_ready, out_valid and cnt. There is no combinational path from in_valid to in_ready.

Decomposition:
- Shared package/header cnn_pkg:
  - default constants DATA_WIDTH, KERNEL_NUM, ACC_WIDTH, OUT_SHIFT
  - clog2 function
  - saturation bounds derived from DATA_WIDTH
- Sub-module requant_sat: combinational round, ReLU and saturate. Parameters ACC_WIDTH, DATA_WIDTH, OUT_SHIFT. Outputs result and sat flag. The pooling/FC stages will reuse it.

Test Plan:
All cases use DATA_WIDTH=8, KERNEL_NUM=9, OUT_SHIFT=7, out_ready=1 unless stated.
- Overflow: nine terms of 16384, bias 0 -> out_data=127, out_sat=1, one cycle after the 9th term.
- Bias and round: nine terms of 100, bias 2 (sum 1156) -> out_data=9, out_sat=0. Same terms with bias 0 -> out_data=7.
- Negative: nine terms of -1000, relu_en=0 -> out_data=-70, out_sat=0. Repeat with relu_en=1 -> out_data=0, out_sat=0.
- Backpressure: hold out_ready=0 with result A (9) pending; stream next window.
  - Terms 1-8 accepted; in_ready=0 at term 9; out_data stays 9.
  - Pulse out_ready -> term 9 accepted in that cycle; result B valid the next cycle.
- Streaming: 18 consecutive terms of 128 with in_valid=1 -> in_ready constantly 1; two results of 9 at cycles 10 and 19.
- Flush and reset: after 4 terms assert clear for 1 cycle, then nine terms of 100 -> out_data=7, not contaminated. Repeat with an asynchronous rst_n pulse mid-cycle -> all outputs 0 immediately, same recovery.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and helpers shared by the CNN datapath blocks
// (accumulator, requantiser, pooling and fully connected stages).
//   DATA_WIDTH / KERNEL_NUM / ACC_WIDTH / OUT_SHIFT : default block parameters
//   clog2()                                         : constant bit-width helper
//   sat_max() / sat_min()                           : signed saturation bounds for a width
package cnn_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int KERNEL_NUM = 9;
   localparam int ACC_WIDTH  = 24;
   localparam int OUT_SHIFT  = 7;

   // Bits needed to hold the values 0..value-1 (at least 1).
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits++;
         rem = rem >> 1;
      end
      return (bits == 0) ? 1 : bits;
   endfunction

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

   localparam int SAT_MAX = int'(sat_max(DATA_WIDTH));
   localparam int SAT_MIN = int'(sat_min(DATA_WIDTH));

endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational requantiser. Rounds an accumulator-scale sum
// half up to output scale, optionally applies ReLU, then saturates to a
// signed DATA_WIDTH result.
//   sum     in  ACC_WIDTH   signed accumulator-scale value
//   relu_en in  1           clamp negative values to zero
//   result  out DATA_WIDTH  signed output-scale value
//   sat     out 1           the saturation clamp changed the value
module requant_sat #(
   parameter int ACC_WIDTH  = cnn_pkg::ACC_WIDTH,
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int OUT_SHIFT  = cnn_pkg::OUT_SHIFT
) (
   input  logic signed [ACC_WIDTH-1:0]  sum,
   input  logic                         relu_en,
   output logic signed [DATA_WIDTH-1:0] result,
   output logic                         sat
);
   import cnn_pkg::*;

   // One guard bit so adding the rounding constant can never wrap.
   localparam int RW = ACC_WIDTH + 1;
   localparam logic signed [RW-1:0] RND =
      (OUT_SHIFT > 0) ? (RW'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
   localparam logic signed [RW-1:0] MAX_V = RW'(sat_max(DATA_WIDTH));
   localparam logic signed [RW-1:0] MIN_V = RW'(sat_min(DATA_WIDTH));

   logic signed [RW-1:0] rounded;
   logic signed [RW-1:0] scaled;
   logic signed [RW-1:0] rectified;

   always_comb begin
      rounded   = RW'(sum) + RND;
      scaled    = rounded >>> OUT_SHIFT;
      rectified = scaled;
      if (relu_en && scaled[RW-1]) begin
         rectified = '0;
      end
      // ReLU runs before the clamp, so a ReLU-only change never raises sat.
      sat    = 1'b0;
      result = rectified[DATA_WIDTH-1:0];
      if (rectified > MAX_V) begin
         result = MAX_V[DATA_WIDTH-1:0];
         sat    = 1'b1;
      end else if (rectified < MIN_V) begin
         result = MIN_V[DATA_WIDTH-1:0];
         sat    = 1'b1;
      end
   end

endmodule

// File: rtl/conv_accum.sv
// conv_accum: accumulates KERNEL_NUM signed products per convolution window,
// adds a per-window bias, requantises the window sum and presents it on a
// valid/ready output.
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush of the window and the output register
//   in_valid/in_ready product handshake; in_prod is the 2*DATA_WIDTH product
//   bias              signed output-scale bias, taken with the first term
//   relu_en           ReLU enable, taken with the last term
//   out_valid/out_ready result handshake; out_data/out_sat hold the result
module conv_accum #(
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int KERNEL_NUM = cnn_pkg::KERNEL_NUM,
   parameter int ACC_WIDTH  = cnn_pkg::ACC_WIDTH,
   parameter int OUT_SHIFT  = cnn_pkg::OUT_SHIFT
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [2*DATA_WIDTH-1:0] in_prod,
   input  logic signed [DATA_WIDTH-1:0]   bias,
   input  logic                           relu_en,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [DATA_WIDTH-1:0]   out_data,
   output logic                           out_sat
);
   import cnn_pkg::*;

   localparam int CNT_W = clog2(KERNEL_NUM);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_NUM - 1);

   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                          out_valid_q, out_valid_d;
   logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                          out_sat_q, out_sat_d;

   logic signed [ACC_WIDTH-1:0]   prod_ext;
   logic signed [ACC_WIDTH-1:0]   bias_ext;
   logic signed [ACC_WIDTH-1:0]   sum;
   logic signed [DATA_WIDTH-1:0]  rq_data;
   logic                          rq_sat;
   logic                          is_last;
   logic                          accept;

   assign prod_ext = ACC_WIDTH'(in_prod);
   assign bias_ext = ACC_WIDTH'(bias) <<< OUT_SHIFT;
   assign sum      = acc_q + prod_ext;
   assign is_last  = (cnt_q == LAST);

   // Only the last term must wait for the held result to drain; earlier
   // terms of the next window keep flowing into the accumulator.
   assign in_ready = !(out_valid_q && !out_ready && is_last);
   assign accept   = in_valid && in_ready;

   requant_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_requant (
      .sum    (sum),
      .relu_en(relu_en),
      .result (rq_data),
      .sat    (rq_sat)
   );

   always_comb begin
      // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latch).
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (cnt_q == '0) begin
            acc_d = prod_ext + bias_ext;
            cnt_d = cnt_q + CNT_W'(1);
         end else if (is_last) begin
            // A new result overrides the handshake drop above.
            cnt_d       = '0;
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
            out_valid_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Flush wins over a term accepted in the same cycle.
      if (clear) begin
         cnt_d       = '0;
         acc_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_sat_d   = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule
